// File: rtl/lane_array_pkg.sv
// Shared constants, lane slice type and count-width helper for the lane array pipeline.
package lane_array_pkg;

    localparam int DEFAULT_NLANES = 8;
    localparam int DEFAULT_LANE_W = 4;
    localparam int DEFAULT_DEPTH  = 2;

    typedef logic [DEFAULT_LANE_W-1:0] lane_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lane_stage.sv
// One lane's DEPTH-slot shift column; slot 0 loads on i_load, slot k takes slot k-1 on i_shift[k-1].
// Latency DEPTH edges to the last slot; never stalls by itself, enables come from the shared control.
module lane_stage
    import lane_array_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = DEFAULT_LANE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DEPTH-1:0] i_shift,
    input  logic [W-1:0]     i_dat,
    output logic [W-1:0]     o_dat
);

    logic [W-1:0] r_slot [DEPTH];
    // The last stage's advance only matters to the valid/count control.
    logic w_unused_last;
    assign w_unused_last = i_shift[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_slot[k] <= '0;
        end else begin
            if (i_load) r_slot[0] <= i_dat;
            for (int k = 1; k < DEPTH; k++) begin
                if (i_shift[k-1]) r_slot[k] <= r_slot[k-1];
            end
        end
    end

    assign o_dat = r_slot[DEPTH-1];

endmodule

// File: rtl/lane_array_pipe.sv
// DEPTH-stage valid/ready lane pipeline with per-lane mask; DEPTH cycles latency, stalls propagate upstream.
// Defining LANE_ARRAY_PIPE_PARITY_EN adds per-lane parity (out_par) computed at capture.
module lane_array_pipe
    import lane_array_pkg::*;
#(
    parameter int NLANES = DEFAULT_NLANES,
    parameter int LANE_W = DEFAULT_LANE_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NLANES*LANE_W-1:0]   in_data,
    input  logic [NLANES-1:0]          in_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NLANES*LANE_W-1:0]   out_data,
    output logic [cnt_w(DEPTH)-1:0]    count
`ifdef LANE_ARRAY_PIPE_PARITY_EN
    ,
    output logic [NLANES-1:0]          out_par
`endif
);

    localparam int CW = cnt_w(DEPTH);
`ifdef LANE_ARRAY_PIPE_PARITY_EN
    localparam int SW = LANE_W + 1;
`else
    localparam int SW = LANE_W;
`endif

    logic [DEPTH-1:0]     r_vld;
    logic [CW-1:0]        r_count;
    logic [DEPTH-1:0]     w_adv;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_out_vld;
    logic [NLANES*SW-1:0] w_cap;
    logic [NLANES*SW-1:0] w_last;

    assign w_out_vld = r_vld[DEPTH-1] & ~rst;

    // A stage moves when it holds a word and the stage ahead is free or moving too.
    always_comb begin
        w_adv          = '0;
        w_adv[DEPTH-1] = w_out_vld & out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            w_adv[k] = r_vld[k] & (~r_vld[k+1] | w_adv[k+1]);
        end
    end

    assign w_pop    = w_adv[DEPTH-1];
    assign in_ready = rst | ~r_vld[0] | w_adv[0];
    assign w_push   = in_valid & in_ready & ~rst;

    always_comb begin
        w_cap = '0;
        for (int k = 0; k < NLANES; k++) begin
            w_cap[k*SW +: LANE_W] = in_mask[k] ? in_data[k*LANE_W +: LANE_W] : '0;
`ifdef LANE_ARRAY_PIPE_PARITY_EN
            w_cap[k*SW + LANE_W] = in_mask[k] & (^in_data[k*LANE_W +: LANE_W]);
`endif
        end
    end

    lane_stage #(.DEPTH(DEPTH), .W(SW)) inst [NLANES-1:0] (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_push),
        .i_shift (w_adv),
        .i_dat   (w_cap),
        .o_dat   (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_count <= '0;
        end else begin
            r_vld[0] <= w_push | (r_vld[0] & ~w_adv[0]);
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= w_adv[k-1] | (r_vld[k] & ~w_adv[k]);
            end
            if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop & ~w_push) r_count <= r_count - CW'(1);
        end
    end

    assign out_valid = w_out_vld;
    assign count     = rst ? '0 : r_count;

    always_comb begin
        out_data = '0;
`ifdef LANE_ARRAY_PIPE_PARITY_EN
        out_par  = '0;
`endif
        for (int k = 0; k < NLANES; k++) begin
            out_data[k*LANE_W +: LANE_W] = w_out_vld ? w_last[k*SW +: LANE_W] : '0;
`ifdef LANE_ARRAY_PIPE_PARITY_EN
            out_par[k] = w_out_vld & w_last[k*SW + LANE_W];
`endif
        end
    end

endmodule

// File: tb/tb_lane_array_pipe.sv
// Directed and random checks of lane_array_pipe against a bounded-FIFO reference model.
module tb_lane_array_pipe;

    localparam int NL = 8;
    localparam int LW = 4;
    localparam int D  = 2;
    localparam int DW = NL * LW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [NL-1:0] in_mask;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    count;
`ifdef LANE_ARRAY_PIPE_PARITY_EN
    logic [NL-1:0] out_par;
`endif

    lane_array_pipe #(.NLANES(NL), .LANE_W(LW), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
`ifdef LANE_ARRAY_PIPE_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a capacity-D FIFO; a word is visible DEPTH cycles after acceptance,
    // but never earlier than the cycle after its predecessor left.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    ent_t q[$];
    int   cyc      = 0;
    int   last_pop = -100;
    int   n_checks = 0;
    int   n_err    = 0;

    logic          obs_vld;
    logic [DW-1:0] obs_dat;
    logic [31:0]   obs_cnt;
    logic          obs_rdy;
    logic [NL-1:0] obs_par;

    function automatic logic [DW-1:0] mask_word(input logic [DW-1:0] d, input logic [NL-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NL; k++) if (m[k]) r[k*LW +: LW] = d[k*LW +: LW];
        return r;
    endfunction

    function automatic logic [NL-1:0] par_of(input logic [DW-1:0] d);
        logic [NL-1:0] p;
        for (int k = 0; k < NL; k++) p[k] = ^d[k*LW +: LW];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic [DW-1:0] d,
                        input logic [NL-1:0] m, input logic ordy);
        logic          e_vld;
        logic [DW-1:0] e_dat;
        int            e_cnt;
        logic          e_rdy;
        int            vis;
        ent_t          e;
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        in_mask   = m;
        out_ready = ordy;
        #5;
        if (r) begin
            e_vld = 1'b0; e_dat = '0; e_cnt = 0; e_rdy = 1'b1;
        end else begin
            e_cnt = q.size();
            e_vld = 1'b0;
            if (q.size() > 0) begin
                vis   = (q[0].t + D > last_pop + 1) ? q[0].t + D : last_pop + 1;
                e_vld = (cyc >= vis);
            end
            e_dat = e_vld ? q[0].d : '0;
            e_rdy = (e_cnt < D) || (e_vld && ordy);
        end
        obs_vld = out_valid;
        obs_dat = out_data;
        obs_cnt = 32'(count);
        obs_rdy = in_ready;
        chk("out_valid", 32'(obs_vld), 32'(e_vld));
        chk("out_data", obs_dat, e_dat);
        chk("count", obs_cnt, 32'(e_cnt));
        chk("in_ready", 32'(obs_rdy), 32'(e_rdy));
`ifdef LANE_ARRAY_PIPE_PARITY_EN
        obs_par = out_par;
        chk("out_par", 32'(obs_par), 32'(e_vld ? par_of(e_dat) : '0));
`else
        obs_par = '0;
`endif
        if (r) begin
            q.delete();
            last_pop = -100;
        end else begin
            if (e_vld && ordy) begin
                void'(q.pop_front());
                last_pop = cyc;
            end
            if (iv && e_rdy) begin
                e.d = mask_word(d, m);
                e.t = cyc;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [DW-1:0] w [6];
        logic [DW-1:0] a, b, c;
        logic [DW-1:0] rd;
        logic [NL-1:0] rm;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset for two cycles, then idle.
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b1, 32'hDEADBEEF, 8'hFF, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("rst_out_valid", 32'(obs_vld), 32'd0);
        chk("rst_out_data", obs_dat, 32'd0);
        chk("rst_count", obs_cnt, 32'd0);
        chk("rst_in_ready", 32'(obs_rdy), 32'd1);

        // Latency: visible exactly two cycles after acceptance.
        step(1'b0, 1'b1, 32'h76543210, 8'hFF, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("lat_not_early", 32'(obs_vld), 32'd0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("lat_valid", 32'(obs_vld), 32'd1);
        chk("lat_data", obs_dat, 32'h76543210);

        // Back-to-back: one output per cycle.
        for (int i = 0; i < 6; i++) w[i] = DW'($urandom);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i < 4), w[i], 8'hFF, 1'b1);
            if (i >= 2) begin
                chk("b2b_valid", 32'(obs_vld), 32'd1);
                chk("b2b_data", obs_dat, w[i-2]);
            end
        end

        // Lane mask.
        step(1'b0, 1'b1, 32'hFFFFFFFF, 8'h0F, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("mask_data", obs_dat, 32'h0000FFFF);

        // Stall: A, B fill the pipe, C waits; then push and pop together while full.
        a = DW'($urandom); b = DW'($urandom); c = DW'($urandom);
        step(1'b0, 1'b1, a, 8'hFF, 1'b0);
        step(1'b0, 1'b1, b, 8'hFF, 1'b0);
        step(1'b0, 1'b1, c, 8'hFF, 1'b0);
        chk("stall_in_ready", 32'(obs_rdy), 32'd0);
        chk("stall_count", obs_cnt, 32'd2);
        step(1'b0, 1'b1, c, 8'hFF, 1'b1);
        chk("order_a", obs_dat, a);
        chk("full_in_ready", 32'(obs_rdy), 32'd1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("full_pushpop_count", obs_cnt, 32'd2);
        chk("order_b", obs_dat, b);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("order_c", obs_dat, c);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("drain_valid", 32'(obs_vld), 32'd0);

        // Reset while full discards in-flight words.
        step(1'b0, 1'b1, a, 8'hFF, 1'b0);
        step(1'b0, 1'b1, b, 8'hFF, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        chk("pre_rst_count", obs_cnt, 32'd2);
        step(1'b1, 1'b1, c, 8'hFF, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("post_rst_count", obs_cnt, 32'd0);
        chk("post_rst_valid", 32'(obs_vld), 32'd0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("post_rst_valid2", 32'(obs_vld), 32'd0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("post_rst_valid3", 32'(obs_vld), 32'd0);

`ifdef LANE_ARRAY_PIPE_PARITY_EN
        step(1'b0, 1'b1, 32'h00000031, 8'hFF, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("par_31", 32'(obs_par), 32'h01);
        step(1'b0, 1'b1, 32'h00000003, 8'hFF, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        chk("par_03", 32'(obs_par), 32'h00);
`endif

        // Random traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            rd = DW'($urandom);
            rm = ($urandom_range(0, 4) == 0) ? 8'hFF : NL'($urandom);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), rd, rm,
                 ($urandom_range(0, 9) < 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
